// File: rtl/cr_prefix_attach_pkg.sv
// Constants for the prefix-attach stage.
// CR_PA_OB_DEPTH        : output buffer entries (power of two, >= 4)
// CR_PA_OB_AFULL_MARGIN : free entries at or below which almost-full asserts
package cr_prefix_attachPKG;

  localparam int CR_PA_OB_DEPTH        = 8;
  localparam int CR_PA_OB_AFULL_MARGIN = 2;

endpackage

// File: rtl/cr_structs.sv
// Shared bus structures for the CR datapath.
// tlvp_if_bus_t : one TLV word as carried between CR pipeline blocks.
package cr_structs;

  typedef struct packed {
    logic        insert;
    logic [7:0]  typen;
    logic        sot;
    logic        eot;
    logic [7:0]  tuser;
    logic [63:0] tdata;
  } tlvp_if_bus_t;

endpackage

// File: rtl/cr_prefix_attach_ob_ram.sv
// Storage array for the prefix-attach output buffer.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : read data
// The array is deliberately not reset; validity is tracked by the pointers.
module cr_prefix_attach_ob_ram #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cr_prefix_attach_ob.sv
// Output buffer of the prefix-attach stage: a first-word-fall-through FIFO
// of tlvp_if_bus_t words with registered full/almost-full flow control,
// a sticky overflow flag and a count of complete frames (eot words) held.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   pac_usr_ob_wr/_tlv  : write strobe and word from the prefix-attach stage
//   usr_ob_full/_afull  : registered full / almost-full back-pressure
//   ob_tlv/_valid       : head-of-FIFO word and its valid flag
//   ob_tlv_rd           : consumer pop (ignored while empty)
//   ob_frame_avail      : at least one stored word carries eot
//   ob_overflow         : sticky, a write arrived while full
//   ob_level            : current occupancy
module cr_prefix_attach_ob
  import cr_structs::*;
  import cr_prefix_attachPKG::*;
#(
  parameter int DEPTH        = CR_PA_OB_DEPTH,
  parameter int AFULL_MARGIN = CR_PA_OB_AFULL_MARGIN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pac_usr_ob_wr,
  input  tlvp_if_bus_t             pac_usr_ob_tlv,
  output logic                     usr_ob_full,
  output logic                     usr_ob_afull,
  output tlvp_if_bus_t             ob_tlv,
  output logic                     ob_tlv_valid,
  input  logic                     ob_tlv_rd,
  output logic                     ob_frame_avail,
  output logic                     ob_overflow,
  output logic [$clog2(DEPTH):0]   ob_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int W  = $bits(tlvp_if_bus_t);
  localparam logic [LW-1:0] ONE_L    = LW'(1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] MARGIN_L = LW'(AFULL_MARGIN);

  logic [LW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LW-1:0] level_nxt, eot_pend, eot_pend_nxt;
  logic          full_q, afull_q, overflow_q;
  logic          full_nxt, afull_nxt;
  logic          push, pop;
  tlvp_if_bus_t  head;

  // Pointers carry one wrap bit: equal means empty, so the head is valid
  // from the cycle after the first write with no same-cycle bypass.
  assign ob_tlv_valid = (wr_ptr != rd_ptr);
  assign push         = pac_usr_ob_wr & ~full_q;
  assign pop          = ob_tlv_rd & ob_tlv_valid;

  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    level_nxt    = ob_level;
    eot_pend_nxt = eot_pend;
    if (push) wr_ptr_nxt = wr_ptr + ONE_L;
    if (pop)  rd_ptr_nxt = rd_ptr + ONE_L;
    case ({push, pop})
      2'b10:   level_nxt = ob_level + ONE_L;
      2'b01:   level_nxt = ob_level - ONE_L;
      default: level_nxt = ob_level;
    endcase
    case ({push & pac_usr_ob_tlv.eot, pop & head.eot})
      2'b10:   eot_pend_nxt = eot_pend + ONE_L;
      2'b01:   eot_pend_nxt = eot_pend - ONE_L;
      default: eot_pend_nxt = eot_pend;
    endcase
    // Flags are registered from next-state values so they line up with
    // the occupancy seen in the following cycle.
    full_nxt  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    afull_nxt = ((DEPTH_L - level_nxt) <= MARGIN_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ob_level   <= '0;
      eot_pend   <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      ob_level   <= level_nxt;
      eot_pend   <= eot_pend_nxt;
      full_q     <= full_nxt;
      afull_q    <= afull_nxt;
      if (pac_usr_ob_wr && full_q) overflow_q <= 1'b1;
    end
  end

  cr_prefix_attach_ob_ram #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (pac_usr_ob_tlv),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  // Stale array contents never leak out: the word is zero while invalid.
  assign ob_tlv         = ob_tlv_valid ? head : '0;
  assign usr_ob_full    = full_q;
  assign usr_ob_afull   = afull_q;
  assign ob_overflow    = overflow_q;
  assign ob_frame_avail = (eot_pend != '0);

endmodule

// File: tb/tb_cr_prefix_attach_ob.sv
// Directed bench for cr_prefix_attach_ob (DEPTH 8, AFULL_MARGIN 2).
module tb_cr_prefix_attach_ob;
  import cr_structs::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr = 1'b0;
  logic         rd = 1'b0;
  tlvp_if_bus_t tlv_in = '0;
  logic         full, afull, valid, frame_avail, overflow;
  tlvp_if_bus_t tlv_out;
  logic [3:0]   level;

  int n_checks = 0;
  int n_errors = 0;

  tlvp_if_bus_t exp_q[$];
  bit           m_ovf = 1'b0;

  always #5 clk = ~clk;

  cr_prefix_attach_ob #(
    .DEPTH        (8),
    .AFULL_MARGIN (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pac_usr_ob_wr  (wr),
    .pac_usr_ob_tlv (tlv_in),
    .usr_ob_full    (full),
    .usr_ob_afull   (afull),
    .ob_tlv         (tlv_out),
    .ob_tlv_valid   (valid),
    .ob_tlv_rd      (rd),
    .ob_frame_avail (frame_avail),
    .ob_overflow    (overflow),
    .ob_level       (level)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tlvp_if_bus_t mk(input int n, input bit eot);
    tlvp_if_bus_t r;
    r.insert = n[0];
    r.typen  = 8'(n * 3);
    r.sot    = (n % 3 == 0);
    r.eot    = eot;
    r.tuser  = 8'(~n);
    r.tdata  = {32'hC0DE0000 ^ 32'(n), 32'(n) * 32'h01010101};
    return r;
  endfunction

  // One clock: drive at negedge, model the edge, release at next negedge.
  task automatic cyc(input bit w, input tlvp_if_bus_t d, input bit r);
    bit was_full;
    bit had;
    was_full = (exp_q.size() == 8);
    had      = (exp_q.size() > 0);
    wr = w; tlv_in = d; rd = r;
    @(posedge clk);
    if (r && had) void'(exp_q.pop_front());
    if (w && !was_full) exp_q.push_back(d);
    if (w && was_full) m_ovf = 1'b1;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; tlv_in = '0;
  endtask

  task automatic check_model(input string tag);
    bit f;
    int sz;
    f  = 1'b0;
    sz = exp_q.size();
    foreach (exp_q[k]) if (exp_q[k].eot) f = 1'b1;
    check({tag, ".level"}, level, sz);
    check({tag, ".full"}, full, sz == 8);
    check({tag, ".afull"}, afull, (8 - sz) <= 2);
    check({tag, ".valid"}, valid, sz > 0);
    if (sz > 0) check({tag, ".tlv"}, tlv_out, exp_q[0]);
    check({tag, ".frame"}, frame_avail, f);
    check({tag, ".ovf"}, overflow, m_ovf);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"}, valid, 0);
    check({tag, ".full"}, full, 0);
    check({tag, ".afull"}, afull, 0);
    check({tag, ".frame"}, frame_avail, 0);
    check({tag, ".ovf"}, overflow, 0);
    check({tag, ".level"}, level, 0);
    check({tag, ".tlv"}, tlv_out, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Eight back-to-back writes.
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, mk(i, 1'b0), 1'b0);
      check($sformatf("fill%0d.level", i), level, i);
      check($sformatf("fill%0d.afull", i), afull, i >= 6);
      check($sformatf("fill%0d.full", i), full, i == 8);
      check($sformatf("fill%0d.valid", i), valid, 1);
    end
    check_model("fill");

    // Ninth write dropped, then write+pop while full.
    cyc(1'b1, mk(99, 1'b1), 1'b0);
    check("ovf9.ovf", overflow, 1);
    check("ovf9.level", level, 8);
    check("ovf9.frame", frame_avail, 0);
    check_model("ovf9");
    check("wrpop_full.head", tlv_out, mk(1, 1'b0));
    cyc(1'b1, mk(98, 1'b1), 1'b1);
    check("wrpop_full.level", level, 7);
    check("wrpop_full.full", full, 0);
    check("wrpop_full.ovf", overflow, 1);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("drain%0d.tlv", i), tlv_out, mk(i, 1'b0));
      cyc(1'b0, '0, 1'b1);
      check_model($sformatf("drain%0d", i));
    end
    check("empty.valid", valid, 0);

    // Pop while empty.
    cyc(1'b0, '0, 1'b1);
    check("pop_empty.level", level, 0);
    check_model("pop_empty");

    // Write into empty FIFO: visible only in the next cycle.
    wr = 1'b1; tlv_in = mk(10, 1'b0);
    #1;
    check("fwft.nobypass", valid, 0);
    cyc(1'b1, mk(10, 1'b0), 1'b0);
    check("fwft.valid", valid, 1);
    check("fwft.tdata", tlv_out.tdata, mk(10, 1'b0).tdata);
    cyc(1'b0, '0, 1'b1);
    check_model("fwft.pop");

    // Level 4 then 20 cycles of simultaneous write and pop.
    for (int i = 0; i < 4; i++) cyc(1'b1, mk(20 + i, 1'b0), 1'b0);
    check("stream.start", level, 4);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, mk(30 + k, (k % 5) == 4), 1'b1);
      check($sformatf("stream%0d.level", k), level, 4);
      check_model($sformatf("stream%0d", k));
    end
    check("stream.last_head", tlv_out, mk(46, 1'b0));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1);
      check_model($sformatf("sdrain%0d", i));
    end

    // Three-word frame, eot on the last word.
    cyc(1'b1, mk(50, 1'b0), 1'b0);
    check("frame.w1", frame_avail, 0);
    cyc(1'b1, mk(51, 1'b0), 1'b0);
    check("frame.w2", frame_avail, 0);
    cyc(1'b1, mk(52, 1'b1), 1'b0);
    check("frame.w3", frame_avail, 1);
    cyc(1'b0, '0, 1'b1);
    check("frame.p1", frame_avail, 1);
    cyc(1'b0, '0, 1'b1);
    check("frame.p2", frame_avail, 1);
    check("frame.p2.head_eot", tlv_out.eot, 1);
    cyc(1'b0, '0, 1'b1);
    check("frame.p3", frame_avail, 0);
    check("frame.p3.valid", valid, 0);

    // Reset mid-operation with level 5.
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(60 + i, i == 2), 1'b0);
    check("prerst.level", level, 5);
    check("prerst.frame", frame_avail, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset("midrst");
    exp_q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    check_reset("midrst.hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_model("postrst");
    cyc(1'b1, mk(70, 1'b0), 1'b0);
    check("postrst.valid", valid, 1);
    check("postrst.tdata", tlv_out.tdata, mk(70, 1'b0).tdata);
    check("postrst.level", level, 1);
    cyc(1'b0, '0, 1'b1);
    check("postrst.pop.valid", valid, 0);
    check_model("postrst.pop");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cr_prefix_attach_ob.md
CR_PREFIX_ATTACH_OB -- requirements
Module: cr_prefix_attach_ob

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; power of two, minimum 4.
REQ-002 Parameter AFULL_MARGIN, default 2, free entries at or below which usr_ob_afull asserts.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pac_usr_ob_wr  input  1  write strobe from prefix-attach stage.
REQ-006 pac_usr_ob_tlv  input  tlvp_if_bus_t  word to store.
REQ-007 usr_ob_full  output  1  no free entries.
REQ-008 usr_ob_afull  output  1  free entries <= AFULL_MARGIN.
REQ-009 ob_tlv  output  tlvp_if_bus_t  head-of-FIFO word.
REQ-010 ob_tlv_valid  output  1  ob_tlv holds a valid word.
REQ-011 ob_tlv_rd  input  1  consumer pop; ignored when ob_tlv_valid is 0.
REQ-012 ob_frame_avail  output  1  at least one stored word has eot set.
REQ-013 ob_overflow  output  1  sticky: a write arrived while full.
REQ-014 ob_level  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 Write accepted when pac_usr_ob_wr=1 and usr_ob_full=0 (registered value).
REQ-016 Write with usr_ob_full=1 is dropped; ob_overflow sets the next cycle and holds until reset.
REQ-017 First-word-fall-through: a word written into an empty FIFO in cycle N shows ob_tlv_valid=1 in cycle N+1; no same-cycle bypass.
REQ-018 Pop when ob_tlv_rd=1 and ob_tlv_valid=1; the next entry is presented in the following cycle.
REQ-019 Simultaneous accepted write and pop: ob_level unchanged; both pointers advance.
REQ-020 Simultaneous write and pop while full: write rejected (full is registered); pop proceeds; ob_overflow sets.
REQ-021 Pop while empty: no pointer or level change.
REQ-022 Pointers are $clog2(DEPTH) bits plus one wrap bit; full = pointers equal except wrap bit; empty = pointers fully equal.
REQ-023 usr_ob_full and usr_ob_afull are registered, computed from next-state ob_level, so they are valid in the cycle after the write that caused them.
REQ-024 eot_pend counter: +1 on an accepted write with eot; -1 on a pop of a word with eot; both in one cycle leaves it unchanged. ob_frame_avail = (eot_pend != 0).
REQ-025 eot_pend width is $clog2(DEPTH)+1 and cannot exceed DEPTH.
REQ-026 Stored words are passed bit-exact; no field of tlvp_if_bus_t is modified.

Reset
REQ-027 On rst_n low: pointers, ob_level and eot_pend clear to 0; ob_tlv_valid=0, usr_ob_full=0, usr_ob_afull=0, ob_frame_avail=0, ob_overflow=0; ob_tlv is driven to 0.
REQ-028 Storage array is not reset.
REQ-029 Reset asserted mid-operation discards all stored words; after release the first accepted write follows REQ-017.

Structure
REQ-030 Constants CR_PA_OB_DEPTH and CR_PA_OB_AFULL_MARGIN go in cr_prefix_attachPKG.
REQ-031 tlvp_if_bus_t comes from cr_structs and is not redefined.
REQ-032 One sub-module, cr_prefix_attach_ob_ram: a DEPTH x $bits(tlvp_if_bus_t) register array with one write port and one asynchronous read port.

Verification
REQ-033 Reset, then 8 back-to-back writes with no pops: usr_ob_afull=1 after the 6th write, usr_ob_full=1 after the 8th, ob_level=8.
REQ-034 Full FIFO, 9th write: word dropped, ob_overflow=1 next cycle, the 8 stored words pop out in order unchanged.
REQ-035 Empty FIFO, write in cycle 10: ob_tlv_valid=1 in cycle 11 with matching tdata.
REQ-036 Level 4, continuous write plus pop for 20 cycles: ob_level stays 4, pointers wrap, output order preserved.
REQ-037 Write a 3-word frame (eot on word 3): ob_frame_avail=1 the cycle after word 3; returns to 0 the cycle after word 3 is popped.
REQ-038 rst_n pulsed low with level 5: all outputs at reset values; a later write and pop behave as in REQ-035.
